// File: rtl/sga_render_pkg.sv
// Shared types and default geometry for the snake matrix renderer.
package sga_render_pkg;

    localparam int DEF_GRID_W  = 6;
    localparam int DEF_GRID_H  = 6;
    localparam int DEF_MAX_LEN = 36;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH,
        PLOT,
        APPLE,
        SWAP
    } render_state_t;

endpackage

// File: rtl/sga_matrix_render_if.sv
// Render request handshake plus the synchronous body-memory read port.
interface sga_matrix_render_if
    import sga_render_pkg::*;
#(
    parameter int GRID_W  = DEF_GRID_W,
    parameter int GRID_H  = DEF_GRID_H,
    parameter int MAX_LEN = DEF_MAX_LEN
);
    localparam int X_W = $clog2(GRID_W);
    localparam int Y_W = $clog2(GRID_H);
    localparam int L_W = $clog2(MAX_LEN + 1);
    localparam int A_W = $clog2(MAX_LEN);

    logic           start;
    logic [L_W-1:0] size;
    logic [X_W-1:0] apple_x;
    logic [Y_W-1:0] apple_y;
    logic           busy;
    logic           done;
    logic [A_W-1:0] seg_addr;
    logic [X_W-1:0] seg_x;
    logic [Y_W-1:0] seg_y;

    modport master (
        output start, size, apple_x, apple_y, seg_x, seg_y,
        input  busy, done, seg_addr
    );

    modport slave (
        input  start, size, apple_x, apple_y, seg_x, seg_y,
        output busy, done, seg_addr
    );

endinterface

// File: rtl/sga_frame_buffer.sv
// Back/front frame pair: the back frame is cleared and drawn cell by cell,
// then copied whole to the front so the display never shows a partial frame.
module sga_frame_buffer #(
    parameter int CELLS = 36,
    parameter int IDX_W = 6
) (
    input  logic             clock,
    input  logic             restart,
    input  logic             clear,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_idx,
    input  logic             swap,
    output logic             cell_lit,
    output logic [CELLS-1:0] front
);

    logic [CELLS-1:0] back;

    // cell_lit reflects the back frame before this cycle's write, which is
    // what collision detection needs.
    assign cell_lit = back[set_idx];

    always_ff @(posedge clock or posedge restart) begin
        if (restart) begin
            back  <= '0;
            front <= '0;
        end else begin
            if (clear) begin
                back <= '0;
            end else if (set_en) begin
                back[set_idx] <= 1'b1;
            end
            if (swap) begin
                front <= back;
            end
        end
    end

endmodule

// File: rtl/sga_matrix_render.sv
// Snake matrix renderer: draws body segments and the apple into a back frame,
// then swaps it to leds. Optional APPLE_BLINK_EN hides the apple every other frame.
module sga_matrix_render
    import sga_render_pkg::*;
#(
    parameter int GRID_W  = DEF_GRID_W,
    parameter int GRID_H  = DEF_GRID_H,
    parameter int MAX_LEN = DEF_MAX_LEN
) (
    input  logic                     clock,
    input  logic                     restart,
    sga_matrix_render_if.slave       bus,
    output logic                     overlap,
    output logic                     apple_hit,
    output logic                     oob,
    output logic [GRID_W*GRID_H-1:0] leds
);

    localparam int X_W   = $clog2(GRID_W);
    localparam int Y_W   = $clog2(GRID_H);
    localparam int L_W   = $clog2(MAX_LEN + 1);
    localparam int A_W   = $clog2(MAX_LEN);
    localparam int CELLS = GRID_W * GRID_H;
    localparam int IDX_W = $clog2(CELLS);

    render_state_t  state;
    logic [L_W-1:0] seg_i;
    logic [L_W-1:0] size_q;
    logic [X_W-1:0] apple_x_q;
    logic [Y_W-1:0] apple_y_q;

    logic             seg_ok;
    logic             apple_ok;
    logic             apple_draw;
    logic             clear_en;
    logic             set_en;
    logic             swap_en;
    logic [IDX_W-1:0] cell_idx;
    logic             cell_lit;

`ifdef APPLE_BLINK_EN
    logic phase;

    always_ff @(posedge clock or posedge restart) begin
        if (restart) begin
            phase <= 1'b0;
        end else if (state == SWAP) begin
            phase <= ~phase;
        end
    end

    assign apple_draw = ~phase;
`else
    assign apple_draw = 1'b1;
`endif

    // The body memory answers one cycle after seg_addr, so segment
    // coordinates are only meaningful in PLOT.
    always_comb begin
        seg_ok   = (int'(bus.seg_x) < GRID_W) && (int'(bus.seg_y) < GRID_H);
        apple_ok = (int'(apple_x_q) < GRID_W) && (int'(apple_y_q) < GRID_H);
        clear_en = (state == CLEAR);
        swap_en  = (state == SWAP);
        set_en   = 1'b0;
        cell_idx = '0;
        case (state)
            PLOT: begin
                if (seg_ok) begin
                    cell_idx = IDX_W'(int'(bus.seg_y) * GRID_W + int'(bus.seg_x));
                end
                set_en = seg_ok;
            end
            APPLE: begin
                if (apple_ok) begin
                    cell_idx = IDX_W'(int'(apple_y_q) * GRID_W + int'(apple_x_q));
                end
                set_en = apple_ok && apple_draw;
            end
            default: ;
        endcase
    end

    sga_frame_buffer #(
        .CELLS (CELLS),
        .IDX_W (IDX_W)
    ) u_frame (
        .clock    (clock),
        .restart  (restart),
        .clear    (clear_en),
        .set_en   (set_en),
        .set_idx  (cell_idx),
        .swap     (swap_en),
        .cell_lit (cell_lit),
        .front    (leds)
    );

    // done leaves the SWAP state together with the front-buffer copy, so the
    // pulse lines up with the cycle leds first shows the new frame.
    always_ff @(posedge clock or posedge restart) begin
        if (restart) begin
            state        <= IDLE;
            seg_i        <= '0;
            size_q       <= '0;
            apple_x_q    <= '0;
            apple_y_q    <= '0;
            bus.seg_addr <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            overlap      <= 1'b0;
            apple_hit    <= 1'b0;
            oob          <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        size_q    <= (bus.size > L_W'(MAX_LEN)) ? L_W'(MAX_LEN) : bus.size;
                        apple_x_q <= bus.apple_x;
                        apple_y_q <= bus.apple_y;
                        overlap   <= 1'b0;
                        apple_hit <= 1'b0;
                        oob       <= 1'b0;
                        seg_i     <= '0;
                        bus.busy  <= 1'b1;
                        state     <= CLEAR;
                    end
                end
                CLEAR: begin
                    seg_i        <= '0;
                    bus.seg_addr <= '0;
                    state        <= (size_q != '0) ? FETCH : APPLE;
                end
                FETCH: begin
                    state <= PLOT;
                end
                PLOT: begin
                    if (!seg_ok) begin
                        oob <= 1'b1;
                    end else if (cell_lit) begin
                        overlap <= 1'b1;
                    end
                    if ((seg_i + L_W'(1)) < size_q) begin
                        seg_i        <= seg_i + L_W'(1);
                        bus.seg_addr <= A_W'(seg_i + L_W'(1));
                        state        <= FETCH;
                    end else begin
                        seg_i        <= '0;
                        bus.seg_addr <= '0;
                        state        <= APPLE;
                    end
                end
                APPLE: begin
                    if (!apple_ok) begin
                        oob <= 1'b1;
                    end else if (cell_lit) begin
                        apple_hit <= 1'b1;
                    end
                    state <= SWAP;
                end
                SWAP: begin
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sga_matrix_render.sv
// Self-checking bench for sga_matrix_render (6x6, MAX_LEN 36); the reference
// model follows APPLE_BLINK_EN when the build defines it.
module tb_sga_matrix_render;

    localparam int W  = 6;
    localparam int H  = 6;
    localparam int ML = 36;

    logic        clock;
    logic        restart;
    logic        overlap;
    logic        apple_hit;
    logic        oob;
    logic [35:0] leds;

    int checks   = 0;
    int failures = 0;

    logic [2:0]  mem_x [ML];
    logic [2:0]  mem_y [ML];
    logic [35:0] prev_leds;
    bit          tb_phase;

    sga_matrix_render_if #(.GRID_W(W), .GRID_H(H), .MAX_LEN(ML)) bus ();

    sga_matrix_render #(.GRID_W(W), .GRID_H(H), .MAX_LEN(ML)) dut (
        .clock     (clock),
        .restart   (restart),
        .bus       (bus),
        .overlap   (overlap),
        .apple_hit (apple_hit),
        .oob       (oob),
        .leds      (leds)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // External body memory with one cycle of read latency.
    always @(posedge clock) begin
        bus.seg_x <= (int'(bus.seg_addr) < ML) ? mem_x[bus.seg_addr] : 3'd0;
        bus.seg_y <= (int'(bus.seg_addr) < ML) ? mem_y[bus.seg_addr] : 3'd0;
    end

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: paint cells on a fresh grid in segment order, then the apple.
    function automatic void model_render(input int n, input int ax, input int ay,
                                         output logic [35:0] exp_leds, output bit ov,
                                         output bit ah, output bit ob, output int cnt);
        bit lit [H][W];
        cnt = (n > ML) ? ML : n;
        ov = 0; ah = 0; ob = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                lit[r][c] = 0;
        for (int k = 0; k < cnt; k++) begin
            int x = int'(mem_x[k]);
            int y = int'(mem_y[k]);
            if (x >= W || y >= H) ob = 1;
            else begin
                if (lit[y][x]) ov = 1;
                lit[y][x] = 1;
            end
        end
        if (ax >= W || ay >= H) ob = 1;
        else begin
            if (lit[ay][ax]) ah = 1;
`ifdef APPLE_BLINK_EN
            if (!tb_phase) lit[ay][ax] = 1;
`else
            lit[ay][ax] = 1;
`endif
        end
        exp_leds = '0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if (lit[r][c]) exp_leds[r * W + c] = 1'b1;
    endfunction

    task automatic apply_stimulus(input string tag, input int n, input int ax, input int ay, input bit poke);
        logic [35:0] exp_leds;
        bit ov, ah, ob;
        int cnt, lat, busy_cycles, dones, hold_bad;
        model_render(n, ax, ay, exp_leds, ov, ah, ob, cnt);
        @(negedge clock);
        bus.start   = 1'b1;
        bus.size    = 6'(n);
        bus.apple_x = 3'(ax);
        bus.apple_y = 3'(ay);
        lat = -1; busy_cycles = 0; dones = 0; hold_bad = 0;
        for (int k = 1; k <= 200 && lat < 0; k++) begin
            @(negedge clock);
            if (k == 1) bus.start = 1'b0;
            if (poke && k == 2) begin bus.start = 1'b1; bus.size = 6'd1; end
            if (poke && k == 3) bus.start = 1'b0;
            if (bus.busy) busy_cycles++;
            if (bus.done) begin
                dones++;
                lat = k - 1;
            end else if (leds !== prev_leds) hold_bad++;
        end
        check_output({tag, "_latency"}, 64'(lat), 64'(3 + 2 * cnt));
        check_output({tag, "_busy"}, 64'(busy_cycles), 64'(3 + 2 * cnt));
        check_output({tag, "_hold"}, 64'(hold_bad), 64'd0);
        check_output({tag, "_leds"}, 64'(leds), 64'(exp_leds));
        check_output({tag, "_overlap"}, 64'(overlap), 64'(ov));
        check_output({tag, "_apple_hit"}, 64'(apple_hit), 64'(ah));
        check_output({tag, "_oob"}, 64'(oob), 64'(ob));
        repeat (4) begin
            @(negedge clock);
            if (bus.done) dones++;
        end
        check_output({tag, "_dones"}, 64'(dones), 64'd1);
        check_output({tag, "_seg_addr_idle"}, 64'(bus.seg_addr), 64'd0);
        check_output({tag, "_flags_hold"}, 64'({overlap, apple_hit, oob}), 64'({ov, ah, ob}));
        prev_leds = exp_leds;
        if (lat >= 0) tb_phase = ~tb_phase;
    endtask

    task automatic abort_render();
        int dones;
        for (int k = 0; k < 10; k++) begin
            mem_x[k] = 3'(k % W);
            mem_y[k] = 3'(k / W);
        end
        @(negedge clock);
        bus.start = 1'b1; bus.size = 6'd10; bus.apple_x = 3'd2; bus.apple_y = 3'd3;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (2) @(negedge clock);
        restart = 1'b1;
        #1;
        check_output("abort_leds", 64'(leds), 64'd0);
        check_output("abort_busy", 64'(bus.busy), 64'd0);
        check_output("abort_seg_addr", 64'(bus.seg_addr), 64'd0);
        @(negedge clock);
        restart = 1'b0;
        dones = 0;
        repeat (30) begin
            @(negedge clock);
            if (bus.done) dones++;
        end
        check_output("abort_no_done", 64'(dones), 64'd0);
        check_output("abort_leds_after", 64'(leds), 64'd0);
        prev_leds = '0;
        tb_phase  = 0;
    endtask

    initial begin
        restart = 1'b1;
        bus.start = 1'b0; bus.size = '0; bus.apple_x = '0; bus.apple_y = '0;
        for (int k = 0; k < ML; k++) begin mem_x[k] = '0; mem_y[k] = '0; end
        prev_leds = '0;
        tb_phase  = 0;
        repeat (2) @(negedge clock);
        check_output("reset_leds", 64'(leds), 64'd0);
        check_output("reset_busy_done", 64'({bus.busy, bus.done}), 64'd0);
        check_output("reset_flags", 64'({overlap, apple_hit, oob}), 64'd0);
        check_output("reset_seg_addr", 64'(bus.seg_addr), 64'd0);
        restart = 1'b0;

        mem_x[0] = 3'd2; mem_y[0] = 3'd2;
        mem_x[1] = 3'd1; mem_y[1] = 3'd2;
        mem_x[2] = 3'd0; mem_y[2] = 3'd2;
        apply_stimulus("basic", 3, 4, 4, 0);
        check_output("basic_frame_const", 64'(leds), 64'h0_1000_7000);

        apply_stimulus("empty", 0, 5, 5, 0);

        mem_x[0] = 3'd1; mem_y[0] = 3'd1;
        mem_x[1] = 3'd1; mem_y[1] = 3'd1;
        apply_stimulus("collide", 2, 1, 1, 0);

        mem_x[0] = 3'd6; mem_y[0] = 3'd0;
        apply_stimulus("oob_poke", 1, 0, 0, 1);

        abort_render();
        mem_x[0] = 3'd3; mem_y[0] = 3'd0;
        apply_stimulus("after_abort", 1, 5, 0, 0);

        apply_stimulus("blink_a", 0, 0, 0, 0);
        apply_stimulus("blink_b", 0, 0, 0, 0);

        for (int t = 0; t < 20; t++) begin
            int n, ax, ay;
            for (int k = 0; k < ML; k++) begin
                mem_x[k] = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
                mem_y[k] = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            end
            n  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(34, 40)) : int'($urandom_range(0, 12));
            ax = ($urandom_range(0, 7) == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5));
            ay = int'($urandom_range(0, 5));
            apply_stimulus("random", n, ax, ay, ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sga_matrix_render.md
SGA_MATRIX_RENDER -- requirements
Module: sga_matrix_render

Interface
REQ-001 SHALL have parameter GRID_W, default 6, number of matrix columns (2..16).
REQ-002 SHALL have parameter GRID_H, default 6, number of matrix rows (2..16).
REQ-003 SHALL have parameter MAX_LEN, default 36, maximum snake segment count (1..GRID_W*GRID_H).
REQ-004 SHALL derive localparams X_W=$clog2(GRID_W), Y_W=$clog2(GRID_H), L_W=$clog2(MAX_LEN+1), A_W=$clog2(MAX_LEN).
REQ-005 SHALL have ports:
  clock      in   1           system clock, rising edge.
  restart    in   1           asynchronous active-high reset.
  start      in   1           one-cycle render request.
  size       in   L_W         segment count to draw, sampled on accepted start.
  seg_addr   out  A_W         segment index driven to the external body memory.
  seg_x      in   X_W         segment column, valid 1 cycle after seg_addr.
  seg_y      in   Y_W         segment row, valid 1 cycle after seg_addr.
  apple_x    in   X_W         apple column, sampled on accepted start.
  apple_y    in   Y_W         apple row, sampled on accepted start.
  busy       out  1           high from the cycle after accepted start until done.
  done       out  1           one-cycle pulse when leds is updated.
  overlap    out  1           a segment landed on an already-lit cell (self-collision).
  apple_hit  out  1           apple cell already lit by a segment.
  oob        out  1           some segment or the apple had x>=GRID_W or y>=GRID_H.
  leds       out  GRID_W*GRID_H  displayed frame, bit index y*GRID_W+x.

Function
REQ-006 SHALL use FSM states IDLE, CLEAR, FETCH, PLOT, APPLE, SWAP.
REQ-007 SHALL accept start only in IDLE; start in any other state is ignored.
REQ-008 On accept SHALL latch size (clamped to MAX_LEN), apple_x, apple_y, and clear overlap/apple_hit/oob; next state CLEAR.
REQ-009 CLEAR: zero the back buffer in one cycle; go to FETCH if latched size>0, else APPLE.
REQ-010 FETCH: drive seg_addr=i (i from 0); next state PLOT.
REQ-011 PLOT: if seg_x/seg_y in range, set back[seg_y*GRID_W+seg_x], setting overlap if already set; else set oob and write nothing.
REQ-012 After PLOT SHALL increment i and return to FETCH while i<size-1, else go to APPLE.
REQ-013 APPLE: if in range, set apple_hit if cell already set, then set the cell; else set oob.
REQ-014 SWAP: copy back buffer to leds, assert done for exactly this cycle, drop busy, return to IDLE.
REQ-015 Render latency, accept to done: 3+2*size cycles (size=0 gives 3).
REQ-016 leds SHALL hold the previous frame throughout a render (double-buffered, never partially drawn).
REQ-017 seg_addr SHALL hold 0 outside FETCH/PLOT.
REQ-018 Flags SHALL stay valid from done until the next accepted start.

Reset
REQ-019 restart SHALL asynchronously force state IDLE, i=0, seg_addr=0, busy=0, done=0, overlap=0, apple_hit=0, oob=0, leds=0, back buffer=0.
REQ-020 restart mid-render SHALL abort the render without any done pulse; leds reads 0.

Configuration
REQ-021 With APPLE_BLINK_EN defined, SHALL keep a 1-bit phase toggled on every SWAP (reset 0), and APPLE SHALL skip the plot when phase=1 (apple_hit/oob still computed).
REQ-022 Without APPLE_BLINK_EN, the apple SHALL be plotted on every frame and no phase register SHALL exist.

Structure
REQ-023 Package sga_render_pkg SHALL hold the FSM state typedef and default GRID_W/GRID_H/MAX_LEN constants.
REQ-024 The back/front frame buffer pair with its clear/set/swap logic SHALL be sub-module sga_frame_buffer; FSM and flags stay in sga_matrix_render.

Verification
REQ-025 6x6, size=3, segments (2,2),(1,2),(0,2), apple (4,4) -> done 9 cycles after start; leds bits 12,13,14,28 set; all flags 0.
REQ-026 size=0, apple (5,5) -> done 3 cycles after start; leds only bit 35; busy high exactly 3 cycles.
REQ-027 Segments (1,1),(1,1), apple (1,1) -> overlap=1, apple_hit=1, leds only bit 7.
REQ-028 Segment (6,0) on 6x6 -> oob=1, nothing written for it; start pulsed while busy -> ignored, exactly one done.
REQ-029 restart asserted in PLOT with size=10 -> immediate IDLE, leds=0, no done; next start renders normally.
REQ-030 APPLE_BLINK_EN defined, two back-to-back renders with apple (0,0) -> bit 0 set in frame 1, clear in frame 2.
